// File: rtl/valid_ready_rr_arbiter.sv
// N-to-1 round-robin arbiter on valid/ready channels with packet locking,
// feeding a 2-entry registered output buffer ahead of the async FIFO sender side.
package datatypes_globals_pkg;
    typedef logic [31:0] rtl_data_t;
endpackage

module valid_ready_rr_arbiter #(
    parameter type DATA_T = datatypes_globals_pkg::rtl_data_t,
    parameter int  NUM_IN = 4,
    parameter int  SRC_W  = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IN-1:0] in_valid,
    input  logic [NUM_IN-1:0] in_last,
    input  DATA_T             in_data [NUM_IN],
    output logic [NUM_IN-1:0] in_ready,
    output logic              out_valid,
    output DATA_T             out_data,
    output logic              out_last,
    output logic [SRC_W-1:0]  out_src,
    input  logic              out_ready
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [SRC_W-1:0] owner_q, owner_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0]       count_q, count_d;
    DATA_T            data_q [2];
    DATA_T            data_d [2];
    logic [1:0]       last_q, last_d;
    logic [SRC_W-1:0] src_q [2];
    logic [SRC_W-1:0] src_d [2];

    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] cand;
    logic [SRC_W-1:0] sel;
    logic [SRC_W-1:0] sel_next;
    logic             any_valid;
    logic             space;
    logic             push;
    logic             pop;
    logic             wr_idx;
    int               idx;

    // Descending scan so the channel closest above rr_ptr wins.
    always_comb begin
        grant     = rr_ptr_q;
        any_valid = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            cand = SRC_W'(idx);
            if (in_valid[cand]) begin
                grant     = cand;
                any_valid = 1'b1;
            end
        end
    end

    assign out_valid = (count_q != 2'd0) && !reset;
    assign out_data  = data_q[0];
    assign out_last  = last_q[0];
    assign out_src   = src_q[0];

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        last_d   = last_q;
        src_d    = src_q;

        sel      = (state_q == LOCKED) ? owner_q : grant;
        sel_next = (sel == SRC_W'(NUM_IN - 1)) ? '0 : sel + 1'b1;
        space    = (count_q != 2'd2);

        // A locked owner keeps ready even through valid gaps inside its packet.
        in_ready = '0;
        if (!reset && space && (state_q == LOCKED || any_valid)) begin
            in_ready[sel] = 1'b1;
        end
        push = in_valid[sel] && in_ready[sel];
        pop  = out_valid && out_ready;

        if (pop) begin
            data_d[0] = data_q[1];
            last_d[0] = last_q[1];
            src_d[0]  = src_q[1];
        end
        wr_idx = (count_q == 2'd1) && !pop;
        if (push) begin
            data_d[wr_idx] = in_data[sel];
            last_d[wr_idx] = in_last[sel];
            src_d[wr_idx]  = sel;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        if (push) begin
            if (in_last[sel]) begin
                state_d  = IDLE;
                rr_ptr_d = sel_next;
            end else begin
                state_d = LOCKED;
                owner_d = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '{default: '0};
            last_q   <= '0;
            src_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            last_q   <= last_d;
            src_q    <= src_d;
        end
    end

endmodule
